axis_bram_trig_writer: RTL and testbench
========================================

Name: axis_bram_trig_writer

Overview:
Triggered successor of the free-running AXI4-Stream-to-BRAM writer. Writes stream samples into a circular BRAM region of configurable length. Two modes:
- Continuous ring capture.
- One-shot triggered capture with programmable pre- and post-trigger sample counts.

Records the trigger address and reports state so software can unwrap the capture buffer.

Parameters:
AXIS_TDATA_WIDTH, 32, stream data width; must be <= BRAM_DATA_WIDTH.
BRAM_DATA_WIDTH, 32, BRAM word width; tdata zero-extended into it.
BRAM_ADDR_WIDTH, 10, BRAM address width.
CNTR_WIDTH, 32, width of pre/post sample counters.

Ports:
aclk  in  1  clock.
aresetn  in  1  synchronous active-low reset.
cfg_last  in  BRAM_ADDR_WIDTH  last ring address; address wraps cfg_last -> 0.
cfg_pre  in  CNTR_WIDTH  pre-trigger samples to write before arming.
cfg_post  in  CNTR_WIDTH  samples written after the trigger sample.
cfg_mode  in  1  0 = continuous, 1 = triggered one-shot.
cfg_run  in  1  rising edge starts capture; low aborts to IDLE.
trg  in  1  trigger qualifier, sampled with a valid beat.
sts_addr  out  BRAM_ADDR_WIDTH  current write address (next to be written).
sts_trig_addr  out  BRAM_ADDR_WIDTH  address holding the trigger sample.
sts_state  out  3  0 IDLE, 1 RUN, 2 PRE, 3 ARMED, 4 POST, 5 DONE.
sts_done  out  1  high in DONE.
s_axis_tdata  in  AXIS_TDATA_WIDTH  sample.
s_axis_tvalid  in  1  sample valid.
s_axis_tready  out  1  constant 1; beats outside writing states are discarded.
b_bram_clk  out  1  = aclk.
b_bram_rst  out  1  = ~aresetn.
b_bram_en  out  1  write strobe.
b_bram_we  out  BRAM_DATA_WIDTH/8  all bits = b_bram_en.
b_bram_addr  out  BRAM_ADDR_WIDTH  = sts_addr.
b_bram_wdata  out  BRAM_DATA_WIDTH  zero-extended s_axis_tdata.

Behaviour:
- Reset (aresetn low at a clock edge): state IDLE, addr 0, trig_addr 0, counters 0, run-edge register 0. All outputs 0 except s_axis_tready = 1, b_bram_rst = 1, b_bram_clk = aclk.
- Writing states: RUN, PRE, ARMED, POST.
  - b_bram_en = s_axis_tvalid when in a writing state, else 0. Combinational, zero latency.
  - Each written beat advances addr on the same edge: if addr == cfg_last then 0, else addr + 1.
- Start: on a cfg_run rising edge (run & ~run_d) in IDLE:
  - addr <- 0, counter <- 0.
  - Next state: RUN if cfg_mode = 0; else PRE if cfg_pre != 0; else ARMED.
- cfg_run low in any state: next edge -> IDLE. addr and trig_addr hold their values for readout. A beat on that edge is still written if the state is a writing state.
- RUN: writes indefinitely, wrapping. No trigger handling.
- PRE: each written beat increments the counter. The beat bringing the counter to cfg_pre moves the state to ARMED. Triggers are ignored in PRE.
- ARMED: a beat with trg = 1 is written as the trigger sample:
  - trig_addr <- addr, counter <- 0.
  - Next state: POST if cfg_post != 0, else DONE.
  - Beats with trg = 0 are written and wrap normally.
- POST: each written beat increments the counter. The beat bringing the counter to cfg_post moves the state to DONE.
- DONE: no writes. Holds until cfg_run goes low. A new rising edge is required to restart.
- A rising edge of cfg_run outside IDLE is ignored.
- trg without tvalid is ignored. No edge detection is applied to trg: a level trg triggers on the first valid beat in ARMED.
- cfg_* inputs are sampled live; software holds them stable while running.
- Counters compare for equality, so they never wrap. cfg_pre or cfg_post > 2^CNTR_WIDTH - 1 is impossible by width.

Test Plan:
- Reset, then mode 0, cfg_last = 7, run rising, 20 continuous valid beats with data 1..20 -> writes to addresses 0..7,0..7,0..3; sts_addr = 4; state RUN; b_bram_en = tvalid.
- Mode 1, cfg_last = 15, pre = 4, post = 3, trg high on beat 10 (values 1..) -> state PRE for beats 1-4, ARMED from beat 5; beat 10 written at address 9, sts_trig_addr = 9; beats 11-13 written at 10-12; DONE; sts_addr = 13; beats 14+ not written.
- Mode 1, pre = 0, post = 0, trg high with first valid beat -> state ARMED straight after start; single write at address 0; trig_addr = 0; DONE one cycle later.
- trg asserted during PRE and with tvalid = 0 in ARMED -> no trigger. Wrap in ARMED with cfg_last = 3 over 10 beats -> addresses 0,1,2,3,0,1,...
- cfg_run dropped mid-POST -> IDLE on next edge; writes stop; sts_addr and sts_trig_addr retained. Re-raising cfg_run restarts from address 0.
- aresetn low mid-capture for 1 cycle -> all state and outputs return to reset values; no write in that cycle.

Source files
------------

// File: rtl/axis_bram_trig_writer.sv
// AXI4-Stream to BRAM ring writer with continuous and one-shot
// triggered capture (pre/post sample counts, trigger address).
//
// Ports:
//   aclk, aresetn     clock, synchronous active-low reset
//   cfg_last          last ring address (wraps to 0 after it)
//   cfg_pre/cfg_post  samples written before arming / after trigger
//   cfg_mode          0 continuous ring, 1 triggered one-shot
//   cfg_run           rising edge starts, low aborts to IDLE
//   trg               trigger qualifier, used only with a valid beat
//   sts_*             write address, trigger address, state, done
//   s_axis_*          sample stream (always ready)
//   b_bram_*          BRAM write port
module axis_bram_trig_writer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_last,
  input  logic [CNTR_WIDTH-1:0]        cfg_pre,
  input  logic [CNTR_WIDTH-1:0]        cfg_post,
  input  logic                         cfg_mode,
  input  logic                         cfg_run,
  input  logic                         trg,
  output logic [BRAM_ADDR_WIDTH-1:0]   sts_addr,
  output logic [BRAM_ADDR_WIDTH-1:0]   sts_trig_addr,
  output logic [2:0]                   sts_state,
  output logic                         sts_done,
  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic                         b_bram_clk,
  output logic                         b_bram_rst,
  output logic                         b_bram_en,
  output logic [BRAM_DATA_WIDTH/8-1:0] b_bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0]   b_bram_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   b_bram_wdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PRE   = 3'd2,
    S_ARMED = 3'd3,
    S_POST  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                     state, state_nxt;
  logic [BRAM_ADDR_WIDTH-1:0] addr, addr_nxt, addr_inc;
  logic [BRAM_ADDR_WIDTH-1:0] trig_addr, trig_nxt;
  logic [CNTR_WIDTH-1:0]      cnt, cnt_nxt, cnt_inc;
  logic                       run_d, run_rise;
  logic                       writing, wr;

  assign writing = (state == S_RUN) || (state == S_PRE) ||
                   (state == S_ARMED) || (state == S_POST);

  // Gated by aresetn so a beat during the reset cycle is not written.
  assign wr       = aresetn & writing & s_axis_tvalid;
  assign run_rise = cfg_run & ~run_d;
  assign addr_inc = (addr == cfg_last) ? '0 : addr + 1'b1;
  assign cnt_inc  = cnt + 1'b1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      addr      <= '0;
      trig_addr <= '0;
      cnt       <= '0;
      run_d     <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      trig_addr <= trig_nxt;
      cnt       <= cnt_nxt;
      run_d     <= cfg_run;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    trig_nxt  = trig_addr;
    cnt_nxt   = cnt;
    if (wr) addr_nxt = addr_inc;
    unique case (state)
      S_IDLE: begin
        if (run_rise) begin
          addr_nxt = '0;
          cnt_nxt  = '0;
          if (!cfg_mode)
            state_nxt = S_RUN;
          else if (cfg_pre != '0)
            state_nxt = S_PRE;
          else
            state_nxt = S_ARMED;
        end
      end
      S_PRE: begin
        if (wr) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == cfg_pre) state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (wr && trg) begin
          trig_nxt  = addr;
          cnt_nxt   = '0;
          state_nxt = (cfg_post != '0) ? S_POST : S_DONE;
        end
      end
      S_POST: begin
        if (wr) begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == cfg_post) state_nxt = S_DONE;
        end
      end
      default: ;
    endcase
    // Abort wins over everything; addresses are kept for readout.
    if (!cfg_run) state_nxt = S_IDLE;
  end

  assign sts_addr      = addr;
  assign sts_trig_addr = trig_addr;
  assign sts_state     = state;
  assign sts_done      = (state == S_DONE);
  assign s_axis_tready = 1'b1;
  assign b_bram_clk    = aclk;
  assign b_bram_rst    = ~aresetn;
  assign b_bram_en     = wr;
  assign b_bram_we     = {(BRAM_DATA_WIDTH/8){wr}};
  assign b_bram_addr   = addr;
  assign b_bram_wdata  = BRAM_DATA_WIDTH'(s_axis_tdata);

endmodule

// File: tb/tb_axis_bram_trig_writer.sv
// Self-checking bench for axis_bram_trig_writer.
// Random stimulus checked against a sample-count reference model.
module tb_axis_bram_trig_writer;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TW = 32;
  localparam int CW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] cfg_last = '0;
  logic [CW-1:0] cfg_pre = '0;
  logic [CW-1:0] cfg_post = '0;
  logic          cfg_mode = 1'b0;
  logic          cfg_run = 1'b0;
  logic          trg = 1'b0;
  logic [AW-1:0] sts_addr, sts_trig_addr;
  logic [2:0]    sts_state;
  logic          sts_done;
  logic [TW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          b_bram_clk, b_bram_rst, b_bram_en;
  logic [DW/8-1:0] b_bram_we;
  logic [AW-1:0] b_bram_addr;
  logic [DW-1:0] b_bram_wdata;

  axis_bram_trig_writer #(
    .AXIS_TDATA_WIDTH(TW), .BRAM_DATA_WIDTH(DW),
    .BRAM_ADDR_WIDTH(AW), .CNTR_WIDTH(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_last(cfg_last), .cfg_pre(cfg_pre), .cfg_post(cfg_post),
    .cfg_mode(cfg_mode), .cfg_run(cfg_run), .trg(trg),
    .sts_addr(sts_addr), .sts_trig_addr(sts_trig_addr),
    .sts_state(sts_state), .sts_done(sts_done),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .b_bram_clk(b_bram_clk), .b_bram_rst(b_bram_rst),
    .b_bram_en(b_bram_en), .b_bram_we(b_bram_we),
    .b_bram_addr(b_bram_addr), .b_bram_wdata(b_bram_wdata)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] got_a[$];
  logic [DW-1:0] got_d[$];
  logic [2:0]    st_seen;
  logic          en_seen, rst_seen;
  logic [DW/8-1:0] we_seen;

  logic          bv[$];
  logic [TW-1:0] bd[$];
  logic          bt[$];
  logic [AW-1:0] exp_a[$];
  logic [DW-1:0] exp_d[$];
  logic [AW-1:0] m_addr;
  logic [AW-1:0] exp_trig = '0;
  logic          m_done;
  logic [2:0]    m_state;

  // Drive one cycle of stimulus, observe the write port before the edge.
  task automatic step(input logic v, input logic [TW-1:0] d, input logic t);
    @(negedge aclk);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    trg           = t;
    #1;
    st_seen  = sts_state;
    en_seen  = b_bram_en;
    we_seen  = b_bram_we;
    rst_seen = b_bram_rst;
    if (b_bram_en) begin
      got_a.push_back(b_bram_addr);
      got_d.push_back(b_bram_wdata);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic add_beat(input logic v, input logic [TW-1:0] d, input logic t);
    bv.push_back(v);
    bd.push_back(d);
    bt.push_back(t);
    step(v, d, t);
  endtask

  // Reference: the k-th written sample lands at k mod (last+1).
  // One-shot capture writes pre samples, then every valid sample until
  // the first one with trg, then post more samples.
  task automatic model(input logic mode, input int last,
                       input int pre, input int post);
    int  n;
    int  npost;
    bit  trigd;
    bit  w;
    n = 0;
    npost = 0;
    trigd = 0;
    exp_a.delete();
    exp_d.delete();
    foreach (bv[i]) begin
      w = 0;
      if (bv[i]) begin
        if (mode == 1'b0) w = 1;
        else if (n < pre) w = 1;
        else if (!trigd) begin
          w = 1;
          if (bt[i]) begin
            trigd = 1;
            exp_trig = AW'(n % (last + 1));
          end
        end else if (npost < post) begin
          w = 1;
          npost++;
        end
        if (w) begin
          exp_a.push_back(AW'(n % (last + 1)));
          exp_d.push_back(DW'(bd[i]));
          n++;
        end
      end
    end
    m_addr = AW'(n % (last + 1));
    m_done = mode && trigd && (npost == post);
    if (!mode) m_state = 3'd1;
    else if (m_done) m_state = 3'd5;
    else if (trigd) m_state = 3'd4;
    else if (n < pre) m_state = 3'd2;
    else m_state = 3'd3;
  endtask

  task automatic check_run(input string name, input logic mode,
                           input int last, input int pre, input int post);
    int bad;
    bad = 0;
    model(mode, last, pre, post);
    checks++;
    if (got_a.size() != exp_a.size()) begin
      failures++;
      $display("FAIL %s_wcount: got %0d expected %0d",
               name, got_a.size(), exp_a.size());
    end else begin
      checks++;
      foreach (exp_a[i])
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) bad++;
      if (bad != 0) begin
        failures++;
        $display("FAIL %s_writes: %0d wrong of %0d", name, bad, exp_a.size());
      end
    end
    checks++;
    if (sts_addr !== m_addr) begin
      failures++;
      $display("FAIL %s_addr: got %0d expected %0d", name, sts_addr, m_addr);
    end
    checks++;
    if (sts_state !== m_state) begin
      failures++;
      $display("FAIL %s_state: got %0d expected %0d", name, sts_state, m_state);
    end
    checks++;
    if (sts_done !== m_done) begin
      failures++;
      $display("FAIL %s_done: got %0d expected %0d", name, sts_done, m_done);
    end
    if (mode) begin
      checks++;
      if (sts_trig_addr !== exp_trig) begin
        failures++;
        $display("FAIL %s_trig: got %0d expected %0d",
                 name, sts_trig_addr, exp_trig);
      end
    end
  endtask

  task automatic start(input string name, input logic mode, input int last,
                       input int pre, input int post);
    logic [2:0] es;
    cfg_mode = mode;
    cfg_last = AW'(last);
    cfg_pre  = CW'(pre);
    cfg_post = CW'(post);
    cfg_run  = 1'b0;
    step(1'b0, '0, 1'b0);
    cfg_run  = 1'b1;
    step(1'b0, '0, 1'b0);
    got_a.delete();
    got_d.delete();
    bv.delete();
    bd.delete();
    bt.delete();
    es = !mode ? 3'd1 : (pre != 0 ? 3'd2 : 3'd3);
    checks++;
    if (sts_state !== es || sts_addr !== '0) begin
      failures++;
      $display("FAIL %s_start: state %0d addr %0d expected state %0d addr 0",
               name, sts_state, sts_addr, es);
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    cfg_run = 1'b0;
    step(1'b1, 32'hA5, 1'b1);
    checks++;
    if (rst_seen !== 1'b1 || en_seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_port: rst %0b en %0b expected rst 1 en 0",
               rst_seen, en_seen);
    end
    aresetn = 1'b1;
    step(1'b0, '0, 1'b0);
    checks++;
    if (sts_state !== 3'd0 || sts_addr !== '0 || sts_trig_addr !== '0 ||
        sts_done !== 1'b0 || b_bram_en !== 1'b0 || b_bram_we !== '0 ||
        s_axis_tready !== 1'b1 || b_bram_rst !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: st %0d addr %0d trig %0d done %0b rdy %0b expected 0 0 0 0 1",
               sts_state, sts_addr, sts_trig_addr, sts_done, s_axis_tready);
    end
    checks++;
    if (b_bram_clk !== aclk) begin
      failures++;
      $display("FAIL reset_clk: got %0b expected %0b", b_bram_clk, aclk);
    end
    // Valid beats in IDLE must not be written.
    step(1'b1, 32'h55, 1'b0);
    checks++;
    if (en_seen !== 1'b0) begin
      failures++;
      $display("FAIL idle_write: got en %0b expected 0", en_seen);
    end
  endtask

  task automatic test_continuous;
    int bad;
    logic v;
    start("cont", 1'b0, 7, 0, 0);
    for (int i = 1; i <= 20; i++) add_beat(1'b1, TW'(i), 1'b0);
    check_run("cont20", 1'b0, 7, 0, 0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 3) != 0);
      add_beat(v, $urandom, $urandom_range(0, 1) == 1);
      if (en_seen !== v || we_seen !== {(DW/8){v}}) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL cont_en: %0d cycles en/we differ from tvalid", bad);
    end
    check_run("cont_rand", 1'b0, 7, 0, 0);
  endtask

  task automatic test_triggered;
    int bad;
    bad = 0;
    start("trig", 1'b1, 15, 4, 3);
    for (int i = 1; i <= 20; i++) begin
      add_beat(1'b1, TW'(i), i == 10);
      if (i <= 4 && st_seen !== 3'd2) bad++;
      if (i >= 5 && i <= 10 && st_seen !== 3'd3) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL trig_phase: %0d beats in wrong PRE/ARMED state", bad);
    end
    check_run("trig", 1'b1, 15, 4, 3);
    checks++;
    if (sts_trig_addr !== 10'd9 || sts_addr !== 10'd13) begin
      failures++;
      $display("FAIL trig_fixed: trig %0d addr %0d expected 9 13",
               sts_trig_addr, sts_addr);
    end
  endtask

  task automatic test_zero_pre_post;
    start("zero", 1'b1, 15, 0, 0);
    add_beat(1'b1, 32'hBEEF, 1'b1);
    checks++;
    if (sts_state !== 3'd5 || sts_trig_addr !== '0 || sts_addr !== 10'd1) begin
      failures++;
      $display("FAIL zero_done: st %0d trig %0d addr %0d expected 5 0 1",
               sts_state, sts_trig_addr, sts_addr);
    end
    for (int i = 0; i < 4; i++) add_beat(1'b1, $urandom, 1'b1);
    check_run("zero", 1'b1, 15, 0, 0);
  endtask

  task automatic test_trig_qual;
    start("qual", 1'b1, 3, 2, 1);
    add_beat(1'b1, 32'd1, 1'b1);
    add_beat(1'b1, 32'd2, 1'b1);
    add_beat(1'b0, 32'd3, 1'b1);
    add_beat(1'b0, 32'd4, 1'b1);
    for (int i = 0; i < 8; i++) add_beat(1'b1, TW'(10 + i), 1'b0);
    check_run("qual_armed", 1'b1, 3, 2, 1);
    add_beat(1'b1, 32'd99, 1'b1);
    add_beat(1'b1, 32'd100, 1'b0);
    add_beat(1'b1, 32'd101, 1'b0);
    check_run("qual", 1'b1, 3, 2, 1);
    checks++;
    if (sts_trig_addr !== 10'd2) begin
      failures++;
      $display("FAIL qual_trig: got %0d expected 2", sts_trig_addr);
    end
  endtask

  task automatic test_random_oneshot;
    int last, pre, post;
    for (int r = 0; r < 8; r++) begin
      last = $urandom_range(2, 15);
      pre  = $urandom_range(0, 6);
      post = $urandom_range(0, 6);
      start("rand", 1'b1, last, pre, post);
      for (int i = 0; i < 40; i++)
        add_beat($urandom_range(0, 3) != 0, $urandom,
                 $urandom_range(0, 7) == 0);
      check_run($sformatf("rand%0d", r), 1'b1, last, pre, post);
    end
  endtask

  task automatic test_abort;
    start("abort", 1'b1, 15, 2, 10);
    for (int i = 1; i <= 6; i++) add_beat(1'b1, TW'(i), i == 4);
    cfg_run = 1'b0;
    step(1'b1, 32'd77, 1'b0);
    checks++;
    if (sts_state !== 3'd0 || sts_addr !== 10'd7 || sts_trig_addr !== 10'd3) begin
      failures++;
      $display("FAIL abort_hold: st %0d addr %0d trig %0d expected 0 7 3",
               sts_state, sts_addr, sts_trig_addr);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 32'd88, 1'b1);
    checks++;
    if (got_a.size() != 7 || got_a[6] !== 10'd6 || got_d[6] !== 32'd77) begin
      failures++;
      $display("FAIL abort_writes: got %0d writes expected 7 ending at 6",
               got_a.size());
    end
    exp_trig = 10'd3;
    cfg_run = 1'b1;
    step(1'b0, '0, 1'b0);
    checks++;
    if (sts_state !== 3'd2 || sts_addr !== '0) begin
      failures++;
      $display("FAIL abort_restart: st %0d addr %0d expected 2 0",
               sts_state, sts_addr);
    end
    got_a.delete();
    got_d.delete();
    step(1'b1, 32'd5, 1'b0);
    checks++;
    if (got_a.size() != 1 || got_a[0] !== '0) begin
      failures++;
      $display("FAIL abort_rewrite: got %0d writes expected 1 at 0",
               got_a.size());
    end
  endtask

  task automatic test_reset_mid;
    start("rmid", 1'b0, 31, 0, 0);
    for (int i = 0; i < 5; i++) add_beat(1'b1, $urandom, 1'b0);
    aresetn = 1'b0;
    cfg_run = 1'b0;
    step(1'b1, 32'h1234, 1'b0);
    checks++;
    if (en_seen !== 1'b0 || rst_seen !== 1'b1) begin
      failures++;
      $display("FAIL rmid_en: en %0b rst %0b expected 0 1", en_seen, rst_seen);
    end
    aresetn = 1'b1;
    exp_trig = '0;
    checks++;
    if (sts_state !== 3'd0 || sts_addr !== '0 || sts_trig_addr !== '0 ||
        sts_done !== 1'b0 || b_bram_en !== 1'b0) begin
      failures++;
      $display("FAIL rmid_state: st %0d addr %0d trig %0d expected 0 0 0",
               sts_state, sts_addr, sts_trig_addr);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_triggered();
    test_zero_pre_post();
    test_trig_qual();
    test_random_oneshot();
    test_abort();
    test_triggered();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
